// File: rtl/serial_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// The state encoding is also used by the bench-visible FSM in serial_pattern_tx.
package serial_pattern_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_pattern_tx_piso.sv
// Parallel-in / serial-out shift register with load, shift and bit-order select.
// The serial output is the register's edge bit: MSB when MSB_FIRST=1, else LSB.
module piso_shreg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      // Shift away from the output end so the next bit lands on sout.
      if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
      else           sreg <= {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign sout = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serializes WIDTH-bit patterns onto dout with a valid/ready input handshake.
// The last-bit cycle accepts the next pattern so frames can run back-to-back.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pat,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int              BCW      = $clog2(WIDTH) + 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0] frame_cnt_nxt;
  logic             last_bit;
  logic             hs;
  logic             load;
  logic             shift;
  logic             sh_out;

  piso_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (pat),
    .sout (sh_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    frame_cnt_nxt = frame_cnt;
    load          = 1'b0;
    shift         = 1'b0;

    last_bit   = (state == SHIFT) && (bit_cnt == LAST_BIT);
    // Ready is masked by rst so nothing handshakes while reset is held.
    pat_ready  = ~rst & ((state == IDLE) | last_bit);
    hs         = pat_valid & pat_ready;
    dout_valid = (state == SHIFT);
    dout       = (state == SHIFT) & sh_out;
    done       = last_bit;

    case (state)
      IDLE: begin
        if (hs) begin
          load        = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          frame_cnt_nxt = frame_cnt + CNT_W'(1);
          bit_cnt_nxt   = '0;
          if (hs) load      = 1'b1;
          else    state_nxt = IDLE;
        end else begin
          shift       = 1'b1;
          bit_cnt_nxt = bit_cnt + BCW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench: drivers push hand-computed bit streams, a negedge monitor
// pops and compares them against an MSB-first and an LSB-first instance.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pat = 4'b0000;
  logic       pat_valid = 1'b0;

  logic       pr_m, d_m, v_m, dn_m;
  logic       pr_l, d_l, v_l, dn_l;
  logic [7:0] fc_m, fc_l;

  typedef struct packed {
    logic d;
    logic dn;
  } exp_t;

  exp_t q[2][$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .pat(pat), .pat_valid(pat_valid), .pat_ready(pr_m),
    .dout(d_m), .dout_valid(v_m), .done(dn_m), .frame_cnt(fc_m)
  );

  serial_pattern_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .pat(pat), .pat_valid(pat_valid), .pat_ready(pr_l),
    .dout(d_l), .dout_valid(v_l), .done(dn_l), .frame_cnt(fc_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int k, input logic d, input logic v, input logic dn);
    exp_t e;
    if (q[k].size() != 0) begin
      chk(k == 0 ? "msb_valid" : "lsb_valid", 32'(v), 32'd1);
      if (v === 1'b1) begin
        e = q[k].pop_front();
        chk(k == 0 ? "msb_bit_done" : "lsb_bit_done", 32'({d, dn}), 32'({e.d, e.dn}));
      end
    end else begin
      chk(k == 0 ? "msb_idle_quiet" : "lsb_idle_quiet", 32'({v, dn}), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon(0, d_m, v_m, dn_m);
      mon(1, d_l, v_l, dn_l);
    end
  end

  // em/el list the expected dout stream, first bit in position 3.
  task automatic send(input logic [3:0] p, input logic [3:0] em, input logic [3:0] el,
                      output int waited);
    waited    = 0;
    pat       = p;
    pat_valid = 1'b1;
    while (pr_m !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (pr_m !== 1'b1) begin
      chk("handshake_timeout", 32'(pr_m), 32'd1);
      pat_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    for (int i = 3; i >= 0; i--) begin
      q[0].push_back('{d: em[i], dn: (i == 0)});
      q[1].push_back('{d: el[i], dn: (i == 0)});
    end
    pat_valid = 1'b0;
    pat       = ~p;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() != 0 || v_m !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_ready",  32'({pr_m, pr_l}), 32'd0);
    chk("rst_valid",  32'({v_m, v_l}),   32'd0);
    chk("rst_done",   32'({dn_m, dn_l}), 32'd0);
    chk("rst_dout",   32'({d_m, d_l}),   32'd0);
    q[0].delete();
    q[1].delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_frame_cnt", 32'({fc_m, fc_l}), 32'd0);
    chk("post_rst_ready", 32'({pr_m, pr_l}), 32'b11);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    #7;
    chk("init_ready", 32'({pr_m, pr_l}), 32'd0);
    chk("init_valid", 32'({v_m, v_l, dn_m, dn_l, d_m, d_l}), 32'd0);
    chk("init_frame_cnt", 32'({fc_m, fc_l}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // single frame, first edge after reset release
    send(4'b1011, 4'b1011, 4'b1101, w);
    chk("first_edge_handshake", 32'(w), 32'd0);
    wait_idle();
    chk("single_frame_cnt", 32'({fc_m, fc_l}), {16'd0, 8'd1, 8'd1});

    // back-to-back frames with no gap
    do_reset();
    send(4'b1011, 4'b1011, 4'b1101, w);
    send(4'b0110, 4'b0110, 4'b0110, w);
    chk("b2b_accept_last_bit", 32'(w), 32'd3);
    wait_idle();
    chk("b2b_frame_cnt", 32'({fc_m, fc_l}), {16'd0, 8'd2, 8'd2});

    // pattern presented while busy waits for the last-bit cycle
    do_reset();
    send(4'b1011, 4'b1011, 4'b1101, w);
    send(4'b1111, 4'b1111, 4'b1111, w);
    chk("busy_wait_cycles", 32'(w), 32'd3);
    wait_idle();
    chk("busy_frame_cnt", 32'({fc_m, fc_l}), {16'd0, 8'd2, 8'd2});

    // abort mid-frame: frame_cnt is 2 going in and must clear
    send(4'b1011, 4'b1011, 4'b1101, w);
    @(negedge clk);
    do_reset();
    repeat (6) @(negedge clk);
    chk("abort_frame_cnt", 32'({fc_m, fc_l}), 32'd0);

    // frame counter wrap
    for (int i = 0; i < 256; i++) send(4'b1011, 4'b1011, 4'b1101, w);
    wait_idle();
    chk("wrap_256", 32'({fc_m, fc_l}), 32'd0);
    send(4'b0110, 4'b0110, 4'b0110, w);
    wait_idle();
    chk("wrap_257", 32'({fc_m, fc_l}), {16'd0, 8'd1, 8'd1});

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 4, gives the pattern length in bits (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port pat, input, WIDTH bits: the parallel pattern to serialize.
REQ-006 Port pat_valid, input, 1 bit: pat holds a pattern to send.
REQ-007 Port pat_ready, output, 1 bit: the block accepts pat on this cycle.
REQ-008 Port dout, output, 1 bit: serial data to the downstream detector.
REQ-009 Port dout_valid, output, 1 bit: dout carries a pattern bit.
REQ-010 Port done, output, 1 bit: one-cycle pulse on the last bit of a frame.
REQ-011 Port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-012 The block shall be a two-state FSM, IDLE and SHIFT, with the state register cleared to IDLE by reset.
REQ-013 A handshake shall occur on any rising edge where pat_valid and pat_ready are both 1.
REQ-014 In IDLE, pat_ready shall be 1, dout shall be 0, and dout_valid and done shall be 0.
REQ-015 On a handshake in IDLE, the block shall load pat into the shift register, clear the bit counter and enter SHIFT.
REQ-016 The first bit shall appear on dout, with dout_valid=1, in the cycle immediately after the handshake edge (latency 1 cycle).
REQ-017 In SHIFT, dout shall come directly from the shift-register output bit, selected by MSB_FIRST, and the register shall shift by one each cycle.
REQ-018 In SHIFT, dout_valid shall be 1 for exactly WIDTH consecutive cycles per frame, tracked by a bit counter of width $clog2(WIDTH)+1.
REQ-019 pat_ready shall be 0 in SHIFT except during the last-bit cycle (counter = WIDTH-1), where it shall be 1.
REQ-020 done shall be 1 only during the last-bit cycle of each frame.
REQ-021 On the last-bit cycle with a handshake, the block shall load the new pattern and stay in SHIFT, giving back-to-back frames with no gap on dout_valid.
REQ-022 On the last-bit cycle without a handshake, the block shall return to IDLE.
REQ-023 pat_valid outside a ready cycle shall be ignored, leaving no state change and no capture.
REQ-024 frame_cnt shall increment by 1 on the edge that ends each completed frame and wrap from 255 to 0.
REQ-025 pat shall be sampled only on the handshake edge; later changes to pat shall not affect a frame in progress.

Reset
REQ-026 rst=1 shall immediately, without a clock edge, set the state to IDLE, the shift register to 0, the bit counter to 0 and frame_cnt to 0.
REQ-027 While rst=1, outputs shall be: pat_ready=0, dout=0, dout_valid=0, done=0.
REQ-028 A reset in mid-frame shall abort the frame; the aborted frame shall not be counted and shall produce no done pulse.
REQ-029 After rst is released, the first handshake shall be possible on the first rising edge where rst=0.

Structure
REQ-030 A package serial_pattern_pkg shall hold the state typedef (IDLE, SHIFT) and the constants DEFAULT_WIDTH=4 and CNT_W=8.
REQ-031 One sub-module, piso_shreg (parallel-in/serial-out register with load, shift and MSB_FIRST select), shall hold the datapath; the FSM, counters and handshake shall live in serial_pattern_tx.

Verification
REQ-032 Bench shall check: rst released, pat=1011 presented once -> dout=1,0,1,1 on four consecutive cycles with dout_valid=1, done on the 4th, frame_cnt=1.
REQ-033 Bench shall check: pat=1011 then pat=0110 held valid -> eight contiguous valid bits 1,0,1,1,0,1,1,0, done on cycles 4 and 8, frame_cnt=2.
REQ-034 Bench shall check: pat_valid=1 with pat=1111 during bits 1-3 of a 1011 frame -> output stays 1,0,1,1, with 1111 accepted only on the last-bit cycle.
REQ-035 Bench shall check: rst pulsed after the 2nd bit of a frame -> dout_valid=0 immediately, no done, frame_cnt=0.
REQ-036 Bench shall check: 256 back-to-back frames -> frame_cnt wraps to 0, and to 1 after the 257th frame.
REQ-037 Bench shall check: MSB_FIRST=0 with pat=1011 -> dout=1,1,0,1.
